pixel_transform_engine: RTL and testbench
=========================================

# pixel_transform_engine

Responder for the `pixel_transform_start` / `pixel_transform_done` handshake issued by the top-level sequencer. On a start pulse it latches six affine coefficients and sweeps every destination pixel in raster order. For each pixel it computes the source coordinate incrementally, reads the captured frame buffer, and writes the resampled pixel into the display frame buffer. When the frame is finished it returns a one-cycle done pulse.

## Interface
Parameters:
- `WIDTH`, 640, frame width in pixels (source and destination)
- `HEIGHT`, 480, frame height in pixels
- `PIX_W`, 12, pixel data width
- `ADDR_W`, 19, frame-buffer address width; must satisfy WIDTH*HEIGHT ≤ 2^ADDR_W
- `COEF_W`, 24, signed coefficient width; fixed-point with FRAC fraction bits
- `FRAC`, 12, number of fraction bits
- `RD_LAT`, 2, source-buffer read latency in cycles

Ports:
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: single-cycle start pulse.
- `done` out 1: one-cycle pulse when the frame is complete.
- `busy` out 1: high while a frame is in progress.
- `coef_xx`, `coef_xy`, `coef_x0` in COEF_W each, signed: x_src = xx·x + xy·y + x0.
- `coef_yx`, `coef_yy`, `coef_y0` in COEF_W each, signed: y_src = yx·x + yy·y + y0.
- `src_addr` out ADDR_W: source read address.
- `src_data` in PIX_W: source data, valid RD_LAT cycles after `src_addr`.
- `dst_addr` out ADDR_W: destination write address.
- `dst_data` out PIX_W: destination write data.
- `dst_we` out 1: destination write enable.

## Operation
- States:
  - IDLE → RUN on `start`.
  - RUN → DRAIN after the last pixel has been issued.
  - DRAIN → DONE when the pipeline is empty.
  - DONE → IDLE unconditionally after one cycle.
- `start` is honoured only in IDLE. It is ignored in RUN, DRAIN and DONE.
- On accept:
  - Latch all six coefficients.
  - Load the row accumulators with (x0, y0) and the pixel accumulators with the same values.
  - Clear the counters: x = 0, y = 0.
- Each RUN cycle issues one pixel:
  - Add xx/yx to the pixel accumulators.
  - At end of row (x = WIDTH−1), add xy/yy to the row accumulators, then copy the row accumulators into the pixel accumulators.
- Accumulator width is COEF_W+11, signed. This width cannot overflow for legal frames.
- Source integer coordinate = arithmetic shift right by FRAC, i.e. floor. Example: −0.5 → −1.
- In range means 0 ≤ sx < WIDTH and 0 ≤ sy < HEIGHT.
- In range: `src_addr` = sy·WIDTH + sx.
- Out of range: `src_addr` = 0 and the pixel is written as 0 (black).
- Destination address = y·WIDTH + x, issued in strict raster order 0 … WIDTH·HEIGHT−1. Every destination address is written exactly once.
- Reset values are 0 for all outputs: `done`, `busy`, `dst_we`, `src_addr`, `dst_addr`, `dst_data`. State returns to IDLE.
- Reset mid-frame aborts the frame immediately. No `done` is produced and no further writes occur.

## Timing
- Cycle 0 is the cycle in which `start` is sampled high in IDLE. N = WIDTH·HEIGHT.
- Cycle 1: state is RUN and `busy` = 1.
- Stage A registers sx, sy and the in-range flag. Stage B registers `src_addr`.
- Pixel k:
  - `src_addr` is driven in cycle 3+k.
  - `src_data` is sampled in cycle 3+k+RD_LAT.
  - `dst_we`/`dst_addr`/`dst_data` are registered and visible in cycle 4+k+RD_LAT.
- Throughput is one pixel per cycle with no stalls.
- Last write occurs in cycle 3+N+RD_LAT.
- `done` is high only in cycle 4+N+RD_LAT. `busy` is low in that same cycle.
- A new `start` is first accepted in cycle 5+N+RD_LAT.
- `dst_we` is 0 whenever no valid pixel occupies the output stage.

## Structure
- Package `pt_pkg` holds:
  - FRAC and COEF_W defaults;
  - the accumulator guard width (11);
  - state encodings IDLE/RUN/DRAIN/DONE.
- Sub-module `affine_stepper` contains the row and pixel accumulators, the x/y counters and the end-of-row/end-of-frame flags. It is instantiated once.
- The address and write pipeline is a valid/address/in-range shift register of depth RD_LAT+2, kept in the top level.

## Test plan
Bench uses WIDTH=4, HEIGHT=3, RD_LAT=2, FRAC=12, N=12, with a source BRAM model where pixel value = address + 100.
- Identity (xx = yy = 4096, others 0), `start` at cycle 0 → writes in cycles 6..17 with dst k = k+100; `done` only in cycle 18; `busy` high in cycles 1..17.
- Shift (identity plus x0 = −4096) → column 0 writes 0; column c>0 writes y·4+(c−1)+100.
- Fractional floor (identity plus x0 = −2048) → column 0 writes 0 (sx = −1); column 1 reads sx = 0.
- Transpose-like (xx=0, xy=4096, yx=4096, yy=0) → dst(x,y) reads src(y,x), and writes 0 where the swapped coordinate exceeds the bounds (e.g. dst(3,0) → sy = 3 ≥ HEIGHT → 0).
- `start` re-pulsed in cycles 5 and 18 → ignored: exactly 12 writes and one `done`. A `start` in cycle 19 begins a new frame.
- `reset` asserted in cycle 10 → all outputs 0 immediately; no `done`; the next `start` runs a full frame correctly.

Source files
------------

// File: rtl/pt_pkg.sv
// pt_pkg: shared defaults, accumulator guard width and FSM state encoding for pixel_transform_engine
package pt_pkg;
  localparam int FRAC_DEF = 12;
  localparam int COEF_W_DEF = 24;
  localparam int GUARD = 11;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
endpackage

// File: rtl/affine_stepper.sv
// affine_stepper: incremental affine source-coordinate accumulators and raster x/y counters (load_i starts a frame, step_i advances one pixel, eof_o flags the last pixel)
module affine_stepper
  import pt_pkg::*;
#(
  parameter int WIDTH = 640,
  parameter int HEIGHT = 480,
  parameter int ADDR_W = 19,
  parameter int COEF_W = COEF_W_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           load_i,
  input  logic                           step_i,
  input  logic signed [COEF_W-1:0]       xx_i,
  input  logic signed [COEF_W-1:0]       xy_i,
  input  logic signed [COEF_W-1:0]       x0_i,
  input  logic signed [COEF_W-1:0]       yx_i,
  input  logic signed [COEF_W-1:0]       yy_i,
  input  logic signed [COEF_W-1:0]       y0_i,
  output logic signed [COEF_W+GUARD-1:0] acc_x_o,
  output logic signed [COEF_W+GUARD-1:0] acc_y_o,
  output logic [ADDR_W-1:0]              x_o,
  output logic [ADDR_W-1:0]              y_o,
  output logic                           eof_o
);
  localparam int AW = COEF_W + GUARD;
  logic signed [AW-1:0] xx_q, xy_q, yx_q, yy_q, row_x_q, row_y_q, pix_x_q, pix_y_q;
  logic [ADDR_W-1:0] x_q, y_q;
  logic eol;
  assign eol = x_q == ADDR_W'(WIDTH - 1);
  assign eof_o = eol && y_q == ADDR_W'(HEIGHT - 1);
  assign acc_x_o = pix_x_q;
  assign acc_y_o = pix_y_q;
  assign x_o = x_q;
  assign y_o = y_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {xx_q, xy_q, yx_q, yy_q} <= '0;
      {row_x_q, row_y_q, pix_x_q, pix_y_q} <= '0;
      x_q <= '0;
      y_q <= '0;
    end else if (load_i) begin
      xx_q <= AW'(xx_i);
      xy_q <= AW'(xy_i);
      yx_q <= AW'(yx_i);
      yy_q <= AW'(yy_i);
      row_x_q <= AW'(x0_i);
      row_y_q <= AW'(y0_i);
      pix_x_q <= AW'(x0_i);
      pix_y_q <= AW'(y0_i);
      x_q <= '0;
      y_q <= '0;
    end else if (step_i) begin
      if (eol) begin
        x_q <= '0;
        y_q <= y_q + 1'b1;
        row_x_q <= row_x_q + xy_q;
        row_y_q <= row_y_q + yy_q;
        pix_x_q <= row_x_q + xy_q;
        pix_y_q <= row_y_q + yy_q;
      end else begin
        x_q <= x_q + 1'b1;
        pix_x_q <= pix_x_q + xx_q;
        pix_y_q <= pix_y_q + yx_q;
      end
    end
endmodule

// File: rtl/pixel_transform_engine.sv
// pixel_transform_engine: affine frame resampler; start/done/busy handshake, six signed coefficients in, src_addr/src_data read port, dst_addr/dst_data/dst_we write port
module pixel_transform_engine
  import pt_pkg::*;
#(
  parameter int WIDTH = 640,
  parameter int HEIGHT = 480,
  parameter int PIX_W = 12,
  parameter int ADDR_W = 19,
  parameter int COEF_W = COEF_W_DEF,
  parameter int FRAC = FRAC_DEF,
  parameter int RD_LAT = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic                     done,
  output logic                     busy,
  input  logic signed [COEF_W-1:0] coef_xx,
  input  logic signed [COEF_W-1:0] coef_xy,
  input  logic signed [COEF_W-1:0] coef_x0,
  input  logic signed [COEF_W-1:0] coef_yx,
  input  logic signed [COEF_W-1:0] coef_yy,
  input  logic signed [COEF_W-1:0] coef_y0,
  output logic [ADDR_W-1:0]        src_addr,
  input  logic [PIX_W-1:0]         src_data,
  output logic [ADDR_W-1:0]        dst_addr,
  output logic [PIX_W-1:0]         dst_data,
  output logic                     dst_we
);
  localparam int AW = COEF_W + GUARD;
  localparam int D = RD_LAT + 2;
  localparam logic signed [AW-1:0] W_S = AW'(WIDTH);
  localparam logic signed [AW-1:0] H_S = AW'(HEIGHT);
  state_e state_q, state_d;
  logic run, eof, in_a;
  logic signed [AW-1:0] acc_x, acc_y, sx, sy;
  logic [ADDR_W-1:0] x, y, sx_q, sy_q, src_addr_q, dst_addr_q;
  logic [D-1:0] v_q, in_q;
  logic [ADDR_W-1:0] a_q [D];
  logic [PIX_W-1:0] dst_data_q;
  logic dst_we_q;
  assign run = state_q == RUN;
  affine_stepper #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .ADDR_W(ADDR_W), .COEF_W(COEF_W)) u_stepper (
    .clk(clk), .rst(reset), .load_i(state_q == IDLE && start), .step_i(run),
    .xx_i(coef_xx), .xy_i(coef_xy), .x0_i(coef_x0), .yx_i(coef_yx), .yy_i(coef_yy), .y0_i(coef_y0),
    .acc_x_o(acc_x), .acc_y_o(acc_y), .x_o(x), .y_o(y), .eof_o(eof)
  );
  // arithmetic shift gives floor, so -0.5 lands on -1 and is out of range
  assign sx = acc_x >>> FRAC;
  assign sy = acc_y >>> FRAC;
  assign in_a = !sx[AW-1] && sx < W_S && !sy[AW-1] && sy < H_S;
  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = RUN;
      RUN:   if (eof) state_d = DRAIN;
      DRAIN: if (~|v_q) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    done = state_q == DONE;
    busy = run || state_q == DRAIN;
  end
  // stage 0 holds sx/sy and the flags; stage 1 drives src_addr; later stages wait out the read latency
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      v_q <= '0;
      in_q <= '0;
      for (int i = 0; i < D; i++) a_q[i] <= '0;
      sx_q <= '0;
      sy_q <= '0;
      src_addr_q <= '0;
      dst_we_q <= 1'b0;
      dst_addr_q <= '0;
      dst_data_q <= '0;
    end else begin
      v_q <= {v_q[D-2:0], run};
      in_q <= {in_q[D-2:0], run && in_a};
      a_q[0] <= y * ADDR_W'(WIDTH) + x;
      for (int i = 1; i < D; i++) a_q[i] <= a_q[i-1];
      sx_q <= ADDR_W'(sx);
      sy_q <= ADDR_W'(sy);
      src_addr_q <= in_q[0] ? sy_q * ADDR_W'(WIDTH) + sx_q : '0;
      dst_we_q <= v_q[D-1];
      dst_addr_q <= v_q[D-1] ? a_q[D-1] : '0;
      dst_data_q <= in_q[D-1] ? src_data : '0;
    end
  assign src_addr = src_addr_q;
  assign dst_we = dst_we_q;
  assign dst_addr = dst_addr_q;
  assign dst_data = dst_data_q;
endmodule

// File: tb/tb_pixel_transform_engine.sv
// tb_pixel_transform_engine: directed bench for pixel_transform_engine on a 4x3 frame with a latency-2 source memory
module tb_pixel_transform_engine;
  localparam int W = 4, H = 3, N = 12, RL = 2, PW = 12, AD = 19, CW = 24;
  logic clk = 0, reset = 1, start = 0;
  logic signed [CW-1:0] cxx = 0, cxy = 0, cx0 = 0, cyx = 0, cyy = 0, cy0 = 0;
  logic done, busy, dst_we;
  logic [AD-1:0] src_addr, dst_addr;
  logic [PW-1:0] src_data = 0, r1 = 0, dst_data;
  int gcyc = 0, nchk = 0, nerr = 0, b, nw, nd, nb;
  logic hb [1024], hd [1024], hw [1024];
  logic [AD-1:0] ha [1024];
  logic [PW-1:0] hx [1024];
  always #5 clk = ~clk;
  pixel_transform_engine #(.WIDTH(W), .HEIGHT(H), .PIX_W(PW), .ADDR_W(AD), .COEF_W(CW), .FRAC(12), .RD_LAT(RL)) dut (
    .clk(clk), .reset(reset), .start(start), .done(done), .busy(busy),
    .coef_xx(cxx), .coef_xy(cxy), .coef_x0(cx0), .coef_yx(cyx), .coef_yy(cyy), .coef_y0(cy0),
    .src_addr(src_addr), .src_data(src_data), .dst_addr(dst_addr), .dst_data(dst_data), .dst_we(dst_we)
  );
  always @(posedge clk) begin
    r1 <= PW'(src_addr + 100);
    src_data <= r1;
    gcyc <= gcyc + 1;
  end
  always @(negedge clk)
    if (gcyc < 1024) begin
      hb[gcyc] = busy;
      hd[gcyc] = done;
      hw[gcyc] = dst_we;
      ha[gcyc] = dst_addr;
      hx[gcyc] = dst_data;
    end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nchk++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  function automatic int model(input int x, input int y);
    int sx, sy;
    sx = (int'(cxx) * x + int'(cxy) * y + int'(cx0)) >>> 12;
    sy = (int'(cyx) * x + int'(cyy) * y + int'(cy0)) >>> 12;
    return (sx >= 0 && sx < W && sy >= 0 && sy < H) ? sy * W + sx + 100 : 0;
  endfunction
  task automatic set_coef(input int xx, input int xy, input int x0, input int yx, input int yy, input int y0);
    cxx = CW'(xx); cxy = CW'(xy); cx0 = CW'(x0);
    cyx = CW'(yx); cyy = CW'(yy); cy0 = CW'(y0);
  endtask
  task automatic check_frame(input string tag, input int fb);
    int cw, cd, cb;
    cw = 0; cd = 0; cb = 0;
    for (int c = 0; c < 25; c++) begin
      cw += int'(hw[fb+c]);
      cd += int'(hd[fb+c]);
    end
    for (int c = 1; c < 18; c++) cb += int'(hb[fb+c]);
    chk({tag, " write count"}, 32'(cw), 32'(N));
    chk({tag, " done count"}, 32'(cd), 1);
    chk({tag, " done at 18"}, 32'(hd[fb+18]), 1);
    chk({tag, " busy at 0"}, 32'(hb[fb]), 0);
    chk({tag, " busy 1..17"}, 32'(cb), 17);
    chk({tag, " busy at 18"}, 32'(hb[fb+18]), 0);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("%s we %0d", tag, k), 32'(hw[fb+6+k]), 1);
      chk($sformatf("%s addr %0d", tag, k), 32'(ha[fb+6+k]), 32'(k));
      chk($sformatf("%s data %0d", tag, k), 32'(hx[fb+6+k]), 32'(model(k % W, k / W)));
    end
  endtask
  task automatic run_frame(input string tag);
    start = 1;
    b = gcyc;
    tick();
    start = 0;
    tick(26);
    check_frame(tag, b);
  endtask
  initial begin
    tick(2);
    chk("reset done", 32'(done), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset we", 32'(dst_we), 0);
    chk("reset src_addr", 32'(src_addr), 0);
    chk("reset dst_addr", 32'(dst_addr), 0);
    chk("reset dst_data", 32'(dst_data), 0);
    reset = 0;
    tick();
    set_coef(4096, 0, 0, 0, 4096, 0);
    run_frame("identity");
    chk("identity px 7", 32'(hx[b+13]), 107);
    set_coef(4096, 0, -4096, 0, 4096, 0);
    run_frame("shift");
    chk("shift px(0,1)", 32'(hx[b+10]), 0);
    chk("shift px(2,1)", 32'(hx[b+12]), 105);
    set_coef(4096, 0, -2048, 0, 4096, 0);
    run_frame("floor");
    chk("floor px(0,0)", 32'(hx[b+6]), 0);
    chk("floor px(1,0)", 32'(hx[b+7]), 100);
    set_coef(0, 4096, 0, 4096, 0, 0);
    run_frame("transpose");
    chk("transpose px(3,0)", 32'(hx[b+9]), 0);
    chk("transpose px(1,2)", 32'(hx[b+15]), 106);
    set_coef(4096, 0, 0, 0, 4096, 0);
    start = 1;
    b = gcyc;
    tick();
    start = 0;
    tick(4);
    start = 1;
    tick();
    start = 0;
    tick(12);
    start = 1;
    tick(2);
    start = 0;
    tick(40);
    check_frame("restart1", b);
    check_frame("restart2", b + 19);
    start = 1;
    b = gcyc;
    tick();
    start = 0;
    tick(9);
    reset = 1;
    #1;
    chk("midreset done", 32'(done), 0);
    chk("midreset busy", 32'(busy), 0);
    chk("midreset we", 32'(dst_we), 0);
    chk("midreset src_addr", 32'(src_addr), 0);
    chk("midreset dst_addr", 32'(dst_addr), 0);
    chk("midreset dst_data", 32'(dst_data), 0);
    tick(2);
    reset = 0;
    tick(30);
    nw = 0; nd = 0; nb = 0;
    for (int c = 10; c < 40; c++) begin
      nw += int'(hw[b+c]);
      nd += int'(hd[b+c]);
      nb += int'(hb[b+c]);
    end
    chk("abort writes", 32'(nw), 0);
    chk("abort done", 32'(nd), 0);
    chk("abort busy", 32'(nb), 0);
    run_frame("after reset");
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
